// File: rtl/cbfp_pkg.sv
// Shared constants and types for the CBFP block de-normalizer.
package cbfp_pkg;

  localparam int unsigned ARRAY_SIZE_DEF      = 16;
  localparam int unsigned DIN_SIZE_DEF        = 13;
  localparam int unsigned DOUT_SIZE_DEF       = 16;
  localparam int unsigned EXP_SIZE_DEF        = 6;
  localparam int unsigned BEATS_PER_BLOCK_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BLOCK = 1'b1
  } state_e;

  typedef logic signed [EXP_SIZE_DEF-1:0] exp_t;

endpackage

// File: rtl/cbfp_lane_shift.sv
// One lane of exponent restore: round-half-up right shift for e > 0,
// saturating left shift for e < 0, shift magnitude clamped to DOUT_SIZE.
module cbfp_lane_shift #(
  parameter int unsigned DIN_SIZE  = cbfp_pkg::DIN_SIZE_DEF,
  parameter int unsigned DOUT_SIZE = cbfp_pkg::DOUT_SIZE_DEF,
  parameter int unsigned EXP_SIZE  = cbfp_pkg::EXP_SIZE_DEF
) (
  input  logic signed [DIN_SIZE-1:0]  din,
  input  logic signed [EXP_SIZE-1:0]  exp_val,
  output logic signed [DOUT_SIZE-1:0] dout_c,
  output logic                        sat_c
);

  // Wide enough that neither the rounding add nor a full left shift overflows.
  localparam int unsigned WW  = DIN_SIZE + DOUT_SIZE + 1;
  localparam int unsigned EW1 = EXP_SIZE + 1;
  localparam int unsigned SHW = $clog2(DOUT_SIZE + 1);

  localparam logic signed [WW-1:0] MAX_V = WW'((64'd1 << (DOUT_SIZE - 1)) - 64'd1);
  localparam logic signed [WW-1:0] MIN_V = ~MAX_V;

  logic signed [EW1-1:0] e_ext;
  logic [EW1-1:0]        mag;
  logic [SHW-1:0]        sh;
  logic                  neg;
  logic                  pos;
  logic signed [WW-1:0]  x;
  logic signed [WW-1:0]  rnd;
  logic signed [WW-1:0]  acc;

  always_comb begin
    e_ext  = EW1'(exp_val);
    neg    = e_ext[EW1-1];
    pos    = !neg && (e_ext != '0);
    mag    = neg ? unsigned'(-e_ext) : unsigned'(e_ext);
    sh     = (mag > EW1'(DOUT_SIZE)) ? SHW'(DOUT_SIZE) : SHW'(mag);
    x      = WW'(din);
    rnd    = '0;
    acc    = x;
    dout_c = DOUT_SIZE'(din);
    sat_c  = 1'b0;
    if (pos) begin
      rnd    = (WW'(1) << sh) >>> 1;
      acc    = (x + rnd) >>> sh;
      dout_c = DOUT_SIZE'(acc);
    end else if (neg) begin
      acc = x <<< sh;
      if (acc > MAX_V) begin
        dout_c = DOUT_SIZE'(MAX_V);
        sat_c  = 1'b1;
      end else if (acc < MIN_V) begin
        dout_c = DOUT_SIZE'(MIN_V);
        sat_c  = 1'b1;
      end else begin
        dout_c = DOUT_SIZE'(acc);
      end
    end
  end

endmodule

// File: rtl/cbfp_denorm.sv
// CBFP decoder-side de-normalizer: block framing FSM plus a 2-stage
// per-lane shift/round/saturate pipeline. Optional CBFP_DENORM_SAT_CNT_EN
// adds a per-block saturated-lane count output.
module cbfp_denorm
  import cbfp_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE      = ARRAY_SIZE_DEF,
  parameter int unsigned DIN_SIZE        = DIN_SIZE_DEF,
  parameter int unsigned DOUT_SIZE       = DOUT_SIZE_DEF,
  parameter int unsigned EXP_SIZE        = EXP_SIZE_DEF,
  parameter int unsigned BEATS_PER_BLOCK = BEATS_PER_BLOCK_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  valid_in,
  input  logic                                  sop_in,
  input  logic signed [EXP_SIZE-1:0]            exp_in,
  input  logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]   din,
  output logic                                  valid_out,
  output logic                                  sop_out,
  output logic                                  eop_out,
  output logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0]  dout,
  output logic                                  err
`ifdef CBFP_DENORM_SAT_CNT_EN
  ,
  output logic [$clog2(ARRAY_SIZE*BEATS_PER_BLOCK):0] sat_cnt
`endif
);

  localparam int unsigned CNT_W = (BEATS_PER_BLOCK > 2) ? $clog2(BEATS_PER_BLOCK) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_BLOCK - 1);

  state_e                               state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic signed [EXP_SIZE-1:0]           exp_q, exp_d;
  logic                                 err_q, err_d;

  logic                                 s1_valid_q, s1_valid_d;
  logic                                 s1_sop_q, s1_sop_d;
  logic                                 s1_eop_q, s1_eop_d;
  logic signed [EXP_SIZE-1:0]           s1_exp_q, s1_exp_d;
  logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]  s1_din_q, s1_din_d;

  logic                                 valid_q, valid_d;
  logic                                 sop_q, sop_d;
  logic                                 eop_q, eop_d;
  logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0] dout_q, dout_d;

  logic                                 accept_c;
  logic                                 beat_sop_c;
  logic                                 beat_eop_c;
  logic signed [EXP_SIZE-1:0]           beat_exp_c;
  logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0] lane_dout_c;
  logic [ARRAY_SIZE-1:0]                lane_sat_c;

  // Block framing: an SOP always opens a fresh block, even mid-block.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    err_d      = 1'b0;
    accept_c   = 1'b0;
    beat_sop_c = 1'b0;
    beat_eop_c = 1'b0;
    beat_exp_c = exp_q;
    if (valid_in && sop_in) begin
      err_d      = (state_q == BLOCK);
      exp_d      = exp_in;
      beat_exp_c = exp_in;
      accept_c   = 1'b1;
      beat_sop_c = 1'b1;
      cnt_d      = CNT_W'(1);
      state_d    = BLOCK;
    end else if (valid_in) begin
      unique case (state_q)
        IDLE: err_d = 1'b1;
        BLOCK: begin
          accept_c   = 1'b1;
          beat_eop_c = (cnt_q == LAST_BEAT);
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage 1 captures the beat with its own block's exponent; stage 2 registers the shifted lanes.
  always_comb begin
    s1_valid_d = accept_c;
    s1_sop_d   = accept_c && beat_sop_c;
    s1_eop_d   = accept_c && beat_eop_c;
    s1_exp_d   = accept_c ? beat_exp_c : s1_exp_q;
    s1_din_d   = accept_c ? din : s1_din_q;
    valid_d    = s1_valid_q;
    sop_d      = s1_valid_q && s1_sop_q;
    eop_d      = s1_valid_q && s1_eop_q;
    dout_d     = s1_valid_q ? lane_dout_c : dout_q;
  end

  for (genvar i = 0; i < int'(ARRAY_SIZE); i++) begin : g_lane
    cbfp_lane_shift #(
      .DIN_SIZE  (DIN_SIZE),
      .DOUT_SIZE (DOUT_SIZE),
      .EXP_SIZE  (EXP_SIZE)
    ) u_lane (
      .din     (s1_din_q[i]),
      .exp_val (s1_exp_q),
      .dout_c  (lane_dout_c[i]),
      .sat_c   (lane_sat_c[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      exp_q      <= '0;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_din_q   <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      s1_valid_q <= s1_valid_d;
      s1_sop_q   <= s1_sop_d;
      s1_eop_q   <= s1_eop_d;
      s1_exp_q   <= s1_exp_d;
      s1_din_q   <= s1_din_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      dout_q     <= dout_d;
    end
  end

  assign valid_out = valid_q;
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;
  assign dout      = dout_q;
  assign err       = err_q;

`ifdef CBFP_DENORM_SAT_CNT_EN
  localparam int unsigned SCW = $clog2(ARRAY_SIZE * BEATS_PER_BLOCK) + 1;

  logic [SCW-1:0] blk_sat_q, blk_sat_d;
  logic [SCW-1:0] sat_cnt_q, sat_cnt_d;
  logic [SCW-1:0] beat_sat_c;

  // Running count for the block in stage 2; published together with eop_out.
  always_comb begin
    beat_sat_c = '0;
    for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
      beat_sat_c = beat_sat_c + SCW'(lane_sat_c[i]);
    end
    blk_sat_d = blk_sat_q;
    sat_cnt_d = sat_cnt_q;
    if (s1_valid_q) begin
      blk_sat_d = (s1_sop_q ? '0 : blk_sat_q) + beat_sat_c;
      if (s1_eop_q) begin
        sat_cnt_d = blk_sat_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_sat_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      blk_sat_q <= blk_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_lane_sat;
  assign unused_lane_sat = ^lane_sat_c;
`endif

endmodule
